// File: rtl/hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_fwd_unit
// Brief    : Depth-parametrised forwarding select, load-use stall and branch
//            flush generator for the in-order RV64 pipeline.
//            Optional HAZARD_STATS_EN adds saturating stall/flush counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_fwd_unit #(
    parameter int REG_W      = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int BR_SLOT    = 1,
    parameter int SEL_W      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             br_taken,
    output logic             stall,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [SEL_W-1:0] fwd_a,
    output logic [SEL_W-1:0] fwd_b
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      flush_cnt
`endif
);

    logic             r_valid    [DEPTH];
    logic [REG_W-1:0] r_rd       [DEPTH];
    logic             r_regwrite [DEPTH];
    logic             r_memread  [DEPTH];
    logic [REG_W-1:0] r_ex_rs1;
    logic [REG_W-1:0] r_ex_rs2;
    logic             r_ex_rs1_used;
    logic             r_ex_rs2_used;

    logic             w_load_hit;
    logic             w_stall;
    logic             w_bubble;

    // x0 is hard-wired zero, so it can never be a producer.
    function automatic logic f_match(input logic             valid,
                                     input logic             regwrite,
                                     input logic [REG_W-1:0] rd,
                                     input logic [REG_W-1:0] r);
        return valid && regwrite && (rd == r) && (r != '0);
    endfunction

    // A load in slot j reaches slot j+1 when the ID instruction enters EX;
    // it must by then be at LOAD_STAGE or older to be forwardable.
    always_comb begin
        w_load_hit = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            if ((j + 1 < LOAD_STAGE) && r_memread[j]) begin
                if ((id_rs1_used && f_match(r_valid[j], r_regwrite[j], r_rd[j], id_rs1)) ||
                    (id_rs2_used && f_match(r_valid[j], r_regwrite[j], r_rd[j], id_rs2))) begin
                    w_load_hit = 1'b1;
                end
            end
        end
    end

    assign w_stall    = id_valid && w_load_hit && !br_taken;
    assign w_bubble   = w_stall || br_taken;
    assign stall      = w_stall;
    assign idex_flush = w_bubble;
    assign ifid_flush = br_taken;

    // Scan oldest to youngest so the youngest matching producer wins.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            if (!(r_memread[k] && (k < LOAD_STAGE))) begin
                if (r_ex_rs1_used && f_match(r_valid[k], r_regwrite[k], r_rd[k], r_ex_rs1)) begin
                    fwd_a = SEL_W'(k);
                end
                if (r_ex_rs2_used && f_match(r_valid[k], r_regwrite[k], r_rd[k], r_ex_rs2)) begin
                    fwd_b = SEL_W'(k);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_valid[k]    <= 1'b0;
                r_rd[k]       <= '0;
                r_regwrite[k] <= 1'b0;
                r_memread[k]  <= 1'b0;
            end
            r_ex_rs1      <= '0;
            r_ex_rs2      <= '0;
            r_ex_rs1_used <= 1'b0;
            r_ex_rs2_used <= 1'b0;
        end else begin
            for (int k = 1; k < DEPTH; k++) begin
                r_rd[k] <= r_rd[k-1];
                // Younger-than-branch entries are wrong-path; the branch moves on intact.
                if (br_taken && (k <= BR_SLOT)) begin
                    r_valid[k]    <= 1'b0;
                    r_regwrite[k] <= 1'b0;
                    r_memread[k]  <= 1'b0;
                end else begin
                    r_valid[k]    <= r_valid[k-1];
                    r_regwrite[k] <= r_regwrite[k-1];
                    r_memread[k]  <= r_memread[k-1];
                end
            end
            r_rd[0]       <= id_rd;
            r_valid[0]    <= id_valid && !w_bubble;
            r_regwrite[0] <= id_regwrite && !w_bubble;
            r_memread[0]  <= id_memread && !w_bubble;
            r_ex_rs1      <= id_rs1;
            r_ex_rs2      <= id_rs2;
            r_ex_rs1_used <= id_rs1_used && id_valid && !w_bubble;
            r_ex_rs2_used <= id_rs2_used && id_valid && !w_bubble;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (br_taken && (r_flush_cnt != 32'hFFFF_FFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_fwd_unit
// Brief    : Scoreboard bench for hazard_fwd_unit (DEPTH=3/LS=2 and DEPTH=4/LS=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_fwd_unit;

    typedef struct packed {
        logic       rst;
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       br;
    } in_t;

    typedef struct packed {
        logic       stall;
        logic       ifid;
        logic       idex;
        logic [1:0] fa;
        logic [1:0] fb;
    } out_t;

    typedef struct {
        int          dut;
        string       name;
        out_t        e;
        bit          cc;
        logic [31:0] sc;
        logic [31:0] fc;
    } ent_t;

    logic clk = 1'b0;
    logic rst_g;
    in_t  in3;
    in_t  in4;
    ent_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    logic       stall3, ifid3, idex3, stall4, ifid4, idex4;
    logic [1:0] fa3, fb3, fa4, fb4;
    out_t       o3, o4;
`ifdef HAZARD_STATS_EN
    logic [31:0] sc3, fc3, sc4, fc4;
`endif

    always #5 clk = ~clk;

    hazard_fwd_unit u_dut3 (
        .clk        (clk),
        .reset      (rst_g | in3.rst),
        .id_valid   (in3.v),
        .id_rs1     (in3.rs1),
        .id_rs2     (in3.rs2),
        .id_rs1_used(in3.u1),
        .id_rs2_used(in3.u2),
        .id_rd      (in3.rd),
        .id_regwrite(in3.rw),
        .id_memread (in3.mr),
        .br_taken   (in3.br),
        .stall      (stall3),
        .ifid_flush (ifid3),
        .idex_flush (idex3),
        .fwd_a      (fa3),
        .fwd_b      (fb3)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt  (sc3),
        .flush_cnt  (fc3)
`endif
    );

    hazard_fwd_unit #(.DEPTH(4), .LOAD_STAGE(3), .BR_SLOT(1)) u_dut4 (
        .clk        (clk),
        .reset      (rst_g | in4.rst),
        .id_valid   (in4.v),
        .id_rs1     (in4.rs1),
        .id_rs2     (in4.rs2),
        .id_rs1_used(in4.u1),
        .id_rs2_used(in4.u2),
        .id_rd      (in4.rd),
        .id_regwrite(in4.rw),
        .id_memread (in4.mr),
        .br_taken   (in4.br),
        .stall      (stall4),
        .ifid_flush (ifid4),
        .idex_flush (idex4),
        .fwd_a      (fa4),
        .fwd_b      (fb4)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt  (sc4),
        .flush_cnt  (fc4)
`endif
    );

    assign o3 = {stall3, ifid3, idex3, fa3, fb3};
    assign o4 = {stall4, ifid4, idex4, fa4, fb4};

    function automatic in_t nop();
        in_t v;
        v = '0;
        return v;
    endfunction

    function automatic in_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        in_t v;
        v = '0;
        v.v = 1'b1; v.rs1 = rs1; v.rs2 = rs2; v.u1 = 1'b1; v.u2 = 1'b1;
        v.rd = rd;  v.rw = 1'b1;
        return v;
    endfunction

    function automatic in_t ld(input logic [4:0] rd, input logic [4:0] rs1);
        in_t v;
        v = '0;
        v.v = 1'b1; v.rs1 = rs1; v.u1 = 1'b1; v.rd = rd; v.rw = 1'b1; v.mr = 1'b1;
        return v;
    endfunction

    function automatic in_t beq(input logic [4:0] rs1, input logic [4:0] rs2);
        in_t v;
        v = '0;
        v.v = 1'b1; v.rs1 = rs1; v.rs2 = rs2; v.u1 = 1'b1; v.u2 = 1'b1;
        return v;
    endfunction

    function automatic in_t with_br(input in_t v);
        in_t r;
        r = v;
        r.br = 1'b1;
        return r;
    endfunction

    function automatic in_t with_rst(input in_t v);
        in_t r;
        r = v;
        r.rst = 1'b1;
        return r;
    endfunction

    function automatic out_t o(input logic s, input logic fi, input logic fx,
                               input logic [1:0] fa, input logic [1:0] fb);
        out_t r;
        r = {s, fi, fx, fa, fb};
        return r;
    endfunction

    // Drive one ID cycle on the selected DUT and queue its expected response.
    task automatic cyc(input int dut, input string name, input in_t v, input out_t e,
                       input bit cc = 1'b0, input logic [31:0] sc = 32'd0,
                       input logic [31:0] fc = 32'd0);
        ent_t m;
        @(posedge clk);
        #1;
        if (dut == 3) begin
            in3 = v;
            in4 = nop();
        end else begin
            in4 = v;
            in3 = nop();
        end
        m.dut = dut; m.name = name; m.e = e; m.cc = cc; m.sc = sc; m.fc = fc;
        q.push_back(m);
    endtask

    always @(negedge clk) begin
        ent_t m;
        out_t got;
        if (q.size() != 0) begin
            m   = q.pop_front();
            got = (m.dut == 3) ? o3 : o4;
            n_total++;
            if (got === m.e) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got stall=%b ifid=%b idex=%b fwd_a=%0d fwd_b=%0d, expected stall=%b ifid=%b idex=%b fwd_a=%0d fwd_b=%0d",
                         m.name, got.stall, got.ifid, got.idex, got.fa, got.fb,
                         m.e.stall, m.e.ifid, m.e.idex, m.e.fa, m.e.fb);
            end
`ifdef HAZARD_STATS_EN
            if (m.cc) begin
                n_total++;
                if (((m.dut == 3) ? sc3 : sc4) === m.sc && ((m.dut == 3) ? fc3 : fc4) === m.fc) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s_cnt: got stall_cnt=%0d flush_cnt=%0d, expected %0d %0d",
                             m.name, (m.dut == 3) ? sc3 : sc4, (m.dut == 3) ? fc3 : fc4, m.sc, m.fc);
                end
            end
`endif
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        rst_g = 1'b1;
        in3   = nop();
        in4   = nop();
        repeat (2) @(posedge clk);
        #1 rst_g = 1'b0;

        cyc(3, "after_reset",  nop(),            o(0, 0, 0, 0, 0));
        // add x5,x1,x2 ; sub x6,x5,x3
        cyc(3, "add5",         alu(5, 1, 2),     o(0, 0, 0, 0, 0));
        cyc(3, "sub6",         alu(6, 5, 3),     o(0, 0, 0, 0, 0));
        cyc(3, "fwd_mem",      nop(),            o(0, 0, 0, 1, 0));
        cyc(3, "idle",         nop(),            o(0, 0, 0, 0, 0));
        // producer two ahead of consumer sits in WB
        cyc(3, "add5_b",       alu(5, 1, 2),     o(0, 0, 0, 0, 0));
        cyc(3, "add10",        alu(10, 1, 2),    o(0, 0, 0, 0, 0));
        cyc(3, "or7",          alu(7, 5, 5),     o(0, 0, 0, 0, 0));
        cyc(3, "fwd_wb",       alu(5, 1, 2),     o(0, 0, 0, 2, 2));
        // two producers of x5: youngest wins
        cyc(3, "add5_young",   alu(5, 3, 4),     o(0, 0, 0, 0, 0));
        cyc(3, "or7_b",        alu(7, 5, 5),     o(0, 0, 0, 0, 0));
        cyc(3, "youngest",     nop(),            o(0, 0, 0, 1, 1));
        // ld x8 ; add x9,x8,x8
        cyc(3, "ld8",          ld(8, 1),         o(0, 0, 0, 0, 0));
        cyc(3, "ld_use_stall", alu(9, 8, 8),     o(1, 0, 1, 0, 0));
        cyc(3, "stall_release",alu(9, 8, 8),     o(0, 0, 0, 0, 0));
        cyc(3, "ld_fwd",       nop(),            o(0, 0, 0, 2, 2));
        // x0 never forwards
        cyc(3, "add0",         alu(0, 1, 2),     o(0, 0, 0, 0, 0));
        cyc(3, "add3_x0",      alu(3, 0, 0),     o(0, 0, 0, 0, 0));
        cyc(3, "x0_no_fwd",    nop(),            o(0, 0, 0, 0, 0));
        // branch resolves while a load-use stall is pending
        cyc(3, "beq",          beq(1, 2),        o(0, 0, 0, 0, 0));
        cyc(3, "ld8_wrong",    ld(8, 1),         o(0, 0, 0, 0, 0));
        cyc(3, "br_over_stall",with_br(alu(9, 8, 8)), o(0, 1, 1, 0, 0));
        cyc(3, "no_stall_flushed", alu(9, 8, 8), o(0, 0, 0, 0, 0));
        cyc(3, "flushed_no_fwd",   nop(),        o(0, 0, 0, 0, 0));
        // reset in the middle of a stall
        cyc(3, "ld8_pre_rst",  ld(8, 1),         o(0, 0, 0, 0, 0), 1'b1, 32'd1, 32'd1);
        cyc(3, "stall_in_rst", with_rst(alu(9, 8, 8)), o(1, 0, 1, 0, 0), 1'b1, 32'd1, 32'd1);
        cyc(3, "post_reset",   alu(9, 8, 8),     o(0, 0, 0, 0, 0), 1'b1, 32'd0, 32'd0);
        cyc(3, "discarded",    nop(),            o(0, 0, 0, 0, 0));

        // DEPTH=4, LOAD_STAGE=3: back-to-back load use stalls twice
        cyc(4, "d4_ld8",       ld(8, 1),         o(0, 0, 0, 0, 0));
        cyc(4, "d4_stall1",    alu(9, 8, 8),     o(1, 0, 1, 0, 0));
        cyc(4, "d4_stall2",    alu(9, 8, 8),     o(1, 0, 1, 0, 0));
        cyc(4, "d4_release",   alu(9, 8, 8),     o(0, 0, 0, 0, 0));
        cyc(4, "d4_fwd3",      nop(),            o(0, 0, 0, 3, 3), 1'b1, 32'd2, 32'd0);

        @(posedge clk);
        #1;
        in3 = nop();
        in4 = nop();
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if (q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: got %0d pending entries, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
